if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//   Parametrised IF->ID pipeline buffer. It replaces the single-entry IF/ID register with a DEPTH-entry FIFO.
//   IF pushes {pc,inst} pairs using a valid/ready handshake. ID consumes the head entry unless it is stalled.
//   A branch flush empties the queue in one cycle. Whenever no valid entry is presented, ID sees a zero bubble.
// PARAMETERS
//   ADDR_W  32  width of the instruction address (pc)
//   INST_W  32  width of the instruction word
//   DEPTH   4   number of entries; a power of two, >=2
// PORTS
//   clk          in   1                    rising-edge clock
//   rst          in   1                    asynchronous reset, active-high
//   rdy          in   1                    global enable; 0 freezes all state
//   if_valid_i   in   1                    IF presents an entry
//   if_pc_i      in   ADDR_W               pc of the entry
//   if_inst_i    in   INST_W               instruction word of the entry
//   if_ready_o   out  1                    queue can accept an entry this cycle
//   stall_i      in   1                    ID stalled; the head entry is not consumed
//   flush_i      in   1                    branch taken; discard all entries
//   id_valid_o   out  1                    the head entry is valid
//   id_pc_o      out  ADDR_W               head pc, or 0 when id_valid_o=0
//   id_inst_o    out  INST_W               head instruction, or 0 when id_valid_o=0
//   count_o      out  $clog2(DEPTH+1)      number of occupied entries
// BEHAVIOUR
//   - Reset (async, any time): rd_ptr=wr_ptr=0, count_o=0.
//     Outputs while in reset: id_valid_o=0, id_pc_o=0, id_inst_o=0, if_ready_o=1.
//     Reset mid-operation drops all entries. Storage contents are don't-care.
//   - rdy=0: no pointer, count or storage update on the clock edge; outputs hold.
//     rst overrides rdy.
//   - if_ready_o = (count_o != DEPTH). This is combinational from state only; it does not depend on pop or flush.
//   - push = rdy & if_valid_i & if_ready_o & ~flush_i
//     pop  = rdy & id_valid_o & ~stall_i & ~flush_i
//   - id_valid_o = (count_o != 0).
//     id_pc_o/id_inst_o = mem[rd_ptr] when valid, else all-zero (bubble).
//   - Latency: an entry pushed at edge N is presented at ID after edge N. It is popped at the first later edge
//     with pop=1. Entries leave in push order.
//   - push & pop together: count unchanged, both pointers advance.
//     This is possible only when 0<count<DEPTH.
//   - Full (count=DEPTH): if_ready_o=0, so there is no push. A pop in that cycle frees an entry, and
//     if_ready_o=1 from the next cycle.
//   - Empty: pop cannot occur. A push makes the entry visible next cycle; there is no same-cycle bypass.
//   - Flush (rdy=1, flush_i=1): at the edge, rd_ptr=wr_ptr=0 and count=0. Any same-cycle push is discarded.
//     flush_i dominates stall_i. The next cycle shows a bubble (id_valid_o=0, zero pc/inst).
//   - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
//     count is kept separately and is never outside 0..DEPTH.
//   - if_valid_i while if_ready_o=0: IF holds its entry; no data is lost or duplicated.
// TESTING
//   1. Async reset mid-cycle with 3 entries queued -> count_o=0, id_valid_o=0 and id_pc/inst=0 immediately,
//      if_ready_o=1.
//   2. Push pc 0x0,0x4,0x8,0xC with stall_i=1 -> count_o=4, if_ready_o=0. ID holds pc 0x0.
//      A 5th push is refused.
//   3. From full, release stall for 4 cycles with no push -> id_pc_o shows 0x0,0x4,0x8,0xC on successive cycles,
//      then a bubble; count_o reaches 0.
//   4. Stream 10 entries with push and pop every cycle -> pointers wrap, order is preserved, count_o stays 1.
//   5. flush_i=1 with count=3 and if_valid_i=1 -> next cycle count_o=0, id_inst_o=0, the pushed entry is absent.
//   6. rdy=0 for 3 cycles with push/pop requested -> count_o and id outputs are unchanged.
//      Operation resumes when rdy=1.

Source files
------------

// File: rtl/if_id_queue_if.sv
// IF->ID queue handshake bundle: IF push side, ID head side and occupancy.
// The pipeline side uses master; the queue itself uses slave.
interface if_id_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
);
   logic                       if_valid_i;
   logic [ADDR_W-1:0]          if_pc_i;
   logic [INST_W-1:0]          if_inst_i;
   logic                       if_ready_o;
   logic                       stall_i;
   logic                       flush_i;
   logic                       id_valid_o;
   logic [ADDR_W-1:0]          id_pc_o;
   logic [INST_W-1:0]          id_inst_o;
   logic [$clog2(DEPTH+1)-1:0] count_o;

   modport master (
      output if_valid_i, if_pc_i, if_inst_i, stall_i, flush_i,
      input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
   );

   modport slave (
      input  if_valid_i, if_pc_i, if_inst_i, stall_i, flush_i,
      output if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
   );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO between IF and ID, with a one-cycle flush.
// An empty queue presents an all-zero bubble to ID.
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input logic         clk,
   input logic         rst,
   input logic         rdy,
   if_id_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              ready;
   logic              valid;
   logic              push;
   logic              pop;

   // ready and valid come from state only, so IF and ID see no
   // combinational path through flush or the other side's handshake.
   assign ready = (count != CW'(DEPTH));
   assign valid = (count != '0);
   assign push  = rdy & q.if_valid_i & ready & ~q.flush_i;
   assign pop   = rdy & valid & ~q.stall_i & ~q.flush_i;

   assign q.if_ready_o = ready;
   assign q.id_valid_o = valid;
   assign q.id_pc_o    = valid ? pc_mem[rd_ptr] : '0;
   assign q.id_inst_o  = valid ? inst_mem[rd_ptr] : '0;
   assign q.count_o    = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (rdy) begin
         if (q.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset; unread slots are masked by valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= q.if_pc_i;
         inst_mem[wr_ptr] <= q.if_inst_i;
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill, drain, streaming,
// flush, global-enable freeze and asynchronous reset.
module tb_if_id_queue;
   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   n_tests = 0;
   int   n_fail  = 0;

   if_id_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) q ();

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .q   (q.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      q.if_valid_i = v;
      q.if_pc_i    = pc;
      q.if_inst_i  = 32'hA000_0000 | pc;
   endtask

   task automatic test_reset();
      n_tests++;
      if (q.count_o !== 3'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d exp 0", q.count_o);
      end
      n_tests++;
      if (q.id_valid_o !== 1'b0 || q.id_pc_o !== 32'h0 || q.id_inst_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_id: got v=%b pc=%h inst=%h exp 0/0/0",
                            q.id_valid_o, q.id_pc_o, q.id_inst_o);
      end
      n_tests++;
      if (q.if_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b exp 1", q.if_ready_o);
      end
   endtask

   task automatic test_fill();
      q.stall_i = 1'b1;
      drive(1'b1, 32'h0);
      tick();
      n_tests++;
      if (q.id_valid_o !== 1'b1 || q.id_pc_o !== 32'h0 || q.id_inst_o !== 32'hA000_0000) begin
         n_fail++; $display("FAIL fill_first: got v=%b pc=%h inst=%h exp 1/0/a0000000",
                            q.id_valid_o, q.id_pc_o, q.id_inst_o);
      end
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, 32'(i * 4));
         tick();
      end
      n_tests++;
      if (q.count_o !== 3'd4 || q.if_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL fill_full: got count=%0d ready=%b exp 4/0",
                            q.count_o, q.if_ready_o);
      end
      drive(1'b1, 32'h10);
      tick();
      n_tests++;
      if (q.count_o !== 3'd4 || q.id_pc_o !== 32'h0) begin
         n_fail++; $display("FAIL fill_refuse: got count=%0d pc=%h exp 4/0",
                            q.count_o, q.id_pc_o);
      end
      drive(1'b0, 32'h0);
   endtask

   task automatic test_drain();
      q.stall_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (q.id_pc_o !== 32'(i * 4) || q.id_inst_o !== (32'hA000_0000 | 32'(i * 4))) begin
            n_fail++; $display("FAIL drain_order[%0d]: got pc=%h inst=%h exp pc=%h",
                               i, q.id_pc_o, q.id_inst_o, i * 4);
         end
         tick();
         if (i == 0) begin
            n_tests++;
            if (q.if_ready_o !== 1'b1 || q.count_o !== 3'd3) begin
               n_fail++; $display("FAIL drain_ready: got ready=%b count=%0d exp 1/3",
                                  q.if_ready_o, q.count_o);
            end
         end
      end
      n_tests++;
      if (q.count_o !== 3'd0 || q.id_valid_o !== 1'b0 ||
          q.id_pc_o !== 32'h0 || q.id_inst_o !== 32'h0) begin
         n_fail++; $display("FAIL drain_bubble: got count=%0d v=%b pc=%h inst=%h exp 0/0/0/0",
                            q.count_o, q.id_valid_o, q.id_pc_o, q.id_inst_o);
      end
   endtask

   task automatic test_stream();
      q.stall_i = 1'b0;
      drive(1'b1, 32'h100);
      tick();
      for (int k = 1; k < 10; k++) begin
         n_tests++;
         if (q.id_pc_o !== 32'(32'h100 + (k - 1) * 4) || q.count_o !== 3'd1) begin
            n_fail++; $display("FAIL stream[%0d]: got pc=%h count=%0d exp pc=%h count=1",
                               k, q.id_pc_o, q.count_o, 32'h100 + (k - 1) * 4);
         end
         drive(1'b1, 32'(32'h100 + k * 4));
         tick();
      end
      n_tests++;
      if (q.id_pc_o !== 32'h124 || q.count_o !== 3'd1) begin
         n_fail++; $display("FAIL stream_last: got pc=%h count=%0d exp 124/1",
                            q.id_pc_o, q.count_o);
      end
      drive(1'b0, 32'h0);
      tick();
      n_tests++;
      if (q.count_o !== 3'd0 || q.id_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL stream_end: got count=%0d v=%b exp 0/0",
                            q.count_o, q.id_valid_o);
      end
   endtask

   task automatic test_flush();
      q.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(32'h200 + i * 4));
         tick();
      end
      n_tests++;
      if (q.count_o !== 3'd3) begin
         n_fail++; $display("FAIL flush_pre: got count=%0d exp 3", q.count_o);
      end
      q.flush_i = 1'b1;
      drive(1'b1, 32'h20C);
      tick();
      q.flush_i = 1'b0;
      drive(1'b0, 32'h0);
      n_tests++;
      if (q.count_o !== 3'd0 || q.id_valid_o !== 1'b0 ||
          q.id_pc_o !== 32'h0 || q.id_inst_o !== 32'h0) begin
         n_fail++; $display("FAIL flush_bubble: got count=%0d v=%b pc=%h inst=%h exp 0/0/0/0",
                            q.count_o, q.id_valid_o, q.id_pc_o, q.id_inst_o);
      end
      tick();
      n_tests++;
      if (q.count_o !== 3'd0) begin
         n_fail++; $display("FAIL flush_discard: got count=%0d exp 0", q.count_o);
      end
      drive(1'b1, 32'h300);
      tick();
      drive(1'b0, 32'h0);
      n_tests++;
      if (q.id_pc_o !== 32'h300 || q.count_o !== 3'd1) begin
         n_fail++; $display("FAIL flush_resume: got pc=%h count=%0d exp 300/1",
                            q.id_pc_o, q.count_o);
      end
      q.stall_i = 1'b0;
      tick();
   endtask

   task automatic test_rdy();
      q.stall_i = 1'b1;
      drive(1'b1, 32'h400);
      tick();
      drive(1'b1, 32'h404);
      tick();
      rdy = 1'b0;
      q.stall_i = 1'b0;
      drive(1'b1, 32'h408);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (q.count_o !== 3'd2 || q.id_pc_o !== 32'h400 || q.id_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rdy_freeze[%0d]: got count=%0d pc=%h exp 2/400",
                               i, q.count_o, q.id_pc_o);
         end
      end
      rdy = 1'b1;
      drive(1'b0, 32'h0);
      tick();
      n_tests++;
      if (q.count_o !== 3'd1 || q.id_pc_o !== 32'h404) begin
         n_fail++; $display("FAIL rdy_resume: got count=%0d pc=%h exp 1/404",
                            q.count_o, q.id_pc_o);
      end
      tick();
      n_tests++;
      if (q.count_o !== 3'd0) begin
         n_fail++; $display("FAIL rdy_empty: got count=%0d exp 0", q.count_o);
      end
   endtask

   task automatic test_async_reset();
      q.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(32'h500 + i * 4));
         tick();
      end
      drive(1'b0, 32'h0);
      n_tests++;
      if (q.count_o !== 3'd3) begin
         n_fail++; $display("FAIL areset_pre: got count=%0d exp 3", q.count_o);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (q.count_o !== 3'd0 || q.id_valid_o !== 1'b0 || q.id_pc_o !== 32'h0 ||
          q.id_inst_o !== 32'h0 || q.if_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL areset: got count=%0d v=%b pc=%h inst=%h ready=%b exp 0/0/0/0/1",
                            q.count_o, q.id_valid_o, q.id_pc_o, q.id_inst_o, q.if_ready_o);
      end
      #1;
      rst = 1'b0;
      q.stall_i = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      q.stall_i = 1'b0;
      q.flush_i = 1'b0;
      drive(1'b0, 32'h0);
      tick();
      test_reset();
      tick();
      rst = 1'b0;
      tick();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_rdy();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
